snitch_icache_perf_cnt: RTL and testbench

Parametrised performance-counter bank for the instruction cache. It counts every L0 event of every fetch port and every L1 event, and exposes the counters through a single-outstanding read port with optional read-and-clear. It sits beside the cache top level and consumes the per-port L0 event vectors and the shared L1 event vector.

---
 rtl/snitch_icache_perf_cnt.sv | 119 +++++++++++
 tb/tb_snitch_icache_perf_cnt.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_perf_cnt.sv
// Performance-counter bank for the instruction cache: one counter per L0 event per fetch port
// plus one per L1 event, read through a single-outstanding port with optional read-and-clear.
// Build option: define SNITCH_ICACHE_PERF_SAT_EN for saturating counters (default wraps).
module snitch_icache_perf_cnt #(
    parameter int unsigned  NR_FETCH_PORTS = 1,
    parameter int unsigned  CNT_WIDTH      = 32,
    localparam int unsigned NUM_CNT        = NR_FETCH_PORTS*5 + 4,
    localparam int unsigned AW             = $clog2(NUM_CNT)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic [NR_FETCH_PORTS*5-1:0] l0_events_i,
    input  logic [3:0]                  l1_events_i,
    input  logic                        rd_req_i,
    input  logic [AW-1:0]               rd_addr_i,
    input  logic                        rd_clr_i,
    output logic                        rd_gnt_o,
    output logic                        rd_rvalid_o,
    output logic [CNT_WIDTH-1:0]        rd_rdata_o,
    output logic [NUM_CNT-1:0]          overflow_o
);

    localparam int unsigned          L1_BASE   = NR_FETCH_PORTS*5;
    localparam logic [AW:0]          NUM_CNT_W = (AW+1)'(NUM_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    // Read handshake: a request is granted in the same cycle unless clear_i is high;
    // each grant produces exactly one rd_rvalid_o pulse on the following cycle.

    logic [NUM_CNT-1:0]   evt;
    logic [NUM_CNT-1:0]   inc;
    logic [NUM_CNT-1:0]   rd_clr_sel;
    logic                 addr_ok;
    logic                 rd_acc;
    logic [CNT_WIDTH-1:0] rd_val;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q;
    logic                 rvalid_q;
    logic [CNT_WIDTH-1:0] rdata_q;

    // Event slices are MSB-first, so counter k of a port reads slice bit 4-k.
    always_comb begin : evt_map
        evt = '0;
        for (int p = 0; p < NR_FETCH_PORTS; p++) begin
            for (int k = 0; k < 5; k++) begin
                evt[5*p+k] = l0_events_i[5*p+4-k];
            end
        end
        for (int j = 0; j < 4; j++) begin
            evt[L1_BASE+j] = l1_events_i[3-j];
        end
    end

    assign inc      = evt & {NUM_CNT{enable_i & ~clear_i}};
    assign rd_gnt_o = rd_req_i & ~clear_i;
    assign addr_ok  = {1'b0, rd_addr_i} < NUM_CNT_W;
    assign rd_acc   = rd_gnt_o & addr_ok;

    always_comb begin : rd_select
        rd_val     = '0;
        rd_clr_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_acc && (rd_addr_i == AW'(i))) begin
                rd_val        = cnt_q[i];
                rd_clr_sel[i] = rd_clr_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : cnt_regs
        if (rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clear_i) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (rd_clr_sel[i]) begin
                    // The event coinciding with read-and-clear is kept, not lost.
                    cnt_q[i] <= CNT_WIDTH'(inc[i]);
                    ovf_q[i] <= 1'b0;
                end else if (inc[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
`ifdef SNITCH_ICACHE_PERF_SAT_EN
                        cnt_q[i] <= CNT_MAX;
`else
                        cnt_q[i] <= '0;
`endif
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : rd_regs
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_gnt_o;
            if (rd_gnt_o) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign rd_rvalid_o = rvalid_q;
    assign rd_rdata_o  = rdata_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Bench for snitch_icache_perf_cnt (2 fetch ports, 4-bit counters): directed stimulus,
// a per-cycle model comparison and literal expectations for the directed scenarios.
module tb_snitch_icache_perf_cnt;

    localparam int NR  = 2;
    localparam int CW  = 4;
    localparam int NUM = NR*5 + 4;
    localparam int AW  = 4;
    localparam int FULL = (1 << CW) - 1;
`ifdef SNITCH_ICACHE_PERF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            enable;
    logic            clear;
    logic [NR*5-1:0] l0_ev;
    logic [3:0]      l1_ev;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_clr;
    logic            rd_gnt;
    logic            rd_rvalid;
    logic [CW-1:0]   rd_rdata;
    logic [NUM-1:0]  ovf;

    snitch_icache_perf_cnt #(
        .NR_FETCH_PORTS(NR),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .clear_i    (clear),
        .l0_events_i(l0_ev),
        .l1_events_i(l1_ev),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_clr_i   (rd_clr),
        .rd_gnt_o   (rd_gnt),
        .rd_rvalid_o(rd_rvalid),
        .rd_rdata_o (rd_rdata),
        .overflow_o (ovf)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: counters as plain integers, events decoded by name from the input slices
    int            m_cnt [NUM];
    logic [NUM-1:0] m_ovf = '0;
    logic          m_rvalid = 1'b0;
    logic [CW-1:0] m_last = '0;
    logic [CW-1:0] exp_q[$];

    function automatic bit cnt_event(input int i);
        if (i < NR*5) begin
            // within a port: miss is the slice MSB, stall the slice LSB
            return l0_ev[5*(i/5) + 4 - (i%5)];
        end
        return l1_ev[3 - (i - NR*5)];
    endfunction

    // Outputs after edge n are compared at the following negedge; the model is then
    // advanced with the inputs that edge n+1 will sample.
    always @(negedge clk) begin : compare
        logic [CW-1:0] e;
        int a;
        bit ev;
        if (rst) begin
            for (int i = 0; i < NUM; i++) m_cnt[i] = 0;
            m_ovf    = '0;
            m_rvalid = 1'b0;
            m_last   = '0;
            exp_q.delete();
        end
        check("rvalid", rd_rvalid, m_rvalid);
        if (m_rvalid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", rd_rdata, e);
            m_last = e;
        end else begin
            check("rdata_hold", rd_rdata, m_last);
        end
        check("overflow", ovf, m_ovf);
        check("gnt", rd_gnt, rd_req & ~clear);
        if (!rst) begin
            a = int'(rd_addr);
            m_rvalid = rd_req & ~clear;
            if (m_rvalid) exp_q.push_back((a < NUM) ? CW'(m_cnt[a]) : '0);
            for (int i = 0; i < NUM; i++) begin
                ev = cnt_event(i) && enable;
                if (clear) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b0;
                end else if (m_rvalid && rd_clr && a == i) begin
                    m_cnt[i] = ev ? 1 : 0;
                    m_ovf[i] = 1'b0;
                end else if (ev) begin
                    if (m_cnt[i] == FULL) begin
                        m_ovf[i] = 1'b1;
                        m_cnt[i] = SAT ? FULL : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int addr, input bit clr, output logic [CW-1:0] data);
        int n;
        rd_req  = 1'b1;
        rd_addr = addr[AW-1:0];
        rd_clr  = clr;
        cycle();
        rd_req = 1'b0;
        rd_clr = 1'b0;
        n = 0;
        while (!rd_rvalid && n < 4) begin
            cycle();
            n++;
        end
        check("rd_response", rd_rvalid, 1'b1);
        data = rd_rdata;
    endtask

    task automatic read_expect(input int addr, input bit clr, input int exp, input string name);
        logic [CW-1:0] d;
        do_read(addr, clr, d);
        check(name, d, exp);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        l0_ev = '0; l1_ev = '0;
        rd_req = 1'b0; rd_addr = '0; rd_clr = 1'b0;
        repeat (2) cycle();
        check("reset_rvalid", rd_rvalid, 1'b0);
        check("reset_rdata", rd_rdata, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;
        enable = 1'b1;
        cycle();

        // port 1 hit for three cycles -> counter 6
        l0_ev = 10'b1 << 8;
        repeat (3) cycle();
        l0_ev = '0;
        read_expect(6, 1'b0, 3, "port1_hit");
        for (int i = 0; i < NUM; i++) begin
            if (i != 6) read_expect(i, 1'b0, 0, "other_zero");
        end

        // L1 miss for ten cycles, read-and-clear while still active
        l1_ev = 4'b1000;
        repeat (10) cycle();
        read_expect(10, 1'b1, 10, "l1_miss_rdclr");
        l1_ev = '0;
        read_expect(10, 1'b0, 1, "l1_miss_after_clr");

        // 17 increments of counter 0 with 4-bit counters
        l0_ev = 10'b1 << 4;
        repeat (17) cycle();
        l0_ev = '0;
        check("ovf0_set", ovf[0], 1'b1);
        read_expect(0, 1'b0, SAT ? 15 : 1, "cnt0_after_17");
        read_expect(0, 1'b1, SAT ? 15 : 1, "cnt0_rdclr");
        check("ovf0_rdclr", ovf[0], 1'b0);

        // clear together with events and a read request
        l0_ev = '1; l1_ev = '1;
        rd_req = 1'b1; rd_addr = 4'd6; clear = 1'b1;
        #1;
        check("clr_gnt", rd_gnt, 1'b0);
        cycle();
        clear = 1'b0; l0_ev = '0; l1_ev = '0; rd_req = 1'b0;
        check("clr_no_rvalid", rd_rvalid, 1'b0);
        check("clr_ovf", ovf, 0);
        for (int i = 0; i < NUM; i++) read_expect(i, 1'b0, 0, "after_clear");

        // enable low freezes counters; out-of-range reads return 0
        l0_ev = 10'b1;
        repeat (2) cycle();
        l0_ev = '0;
        enable = 1'b0;
        l0_ev = '1; l1_ev = '1;
        repeat (5) cycle();
        l0_ev = '0; l1_ev = '0;
        enable = 1'b1;
        read_expect(4, 1'b0, 2, "frozen_cnt4");
        read_expect(13, 1'b0, 0, "frozen_cnt13");
        read_expect(NUM, 1'b1, 0, "addr_oob");
        read_expect(15, 1'b0, 0, "addr_oob15");
        read_expect(4, 1'b0, 2, "cnt4_after_oob_clr");

        // asynchronous reset one cycle after a granted read
        l1_ev = 4'b0010;
        repeat (3) cycle();
        l1_ev = '0;
        rd_req = 1'b1; rd_addr = 4'd12; rd_clr = 1'b0;
        cycle();
        rd_req = 1'b0;
        check("pre_rst_rvalid", rd_rvalid, 1'b1);
        check("pre_rst_rdata", rd_rdata, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_rvalid", rd_rvalid, 1'b0);
        check("rst_rdata", rd_rdata, 0);
        check("rst_ovf", ovf, 0);
        rd_req = 1'b1; rd_addr = 4'd12;
        cycle();
        #2 rst = 1'b0;
        cycle();
        rd_req = 1'b0;
        check("post_rst_rvalid", rd_rvalid, 1'b1);
        check("post_rst_rdata", rd_rdata, 0);
        read_expect(4, 1'b0, 0, "post_rst_cnt4");
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
